// File: rtl/write_back.sv
// Write-back stage and architectural register file of the SEQ Y86-64 core.
// Decodes destE/destM from icode, rA, rB and the condition flag, commits
// val_e/val_m on the rising clock edge, and serves two combinational read
// ports to decode. ID RNONE is never written and always reads as zero.
module write_back #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 15,
    parameter int RSP_ID = 4,
    parameter int RNONE  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cnd,
    input  logic [3:0]       in_code,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic [WIDTH-1:0] val_e,
    input  logic [WIDTH-1:0] val_m,
    input  logic [3:0]       src_a,
    input  logic [3:0]       src_b,
    output logic [WIDTH-1:0] val_a,
    output logic [WIDTH-1:0] val_b,
    output logic [3:0]       dst_e,
    output logic [3:0]       dst_m
);

    localparam logic [3:0] RNONE_ID = 4'(RNONE);
    localparam logic [3:0] RSP      = 4'(RSP_ID);

    // Y86-64 instruction codes that take part in write-back
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Destination decode; any code not listed (including C..F) writes nothing
    always_comb begin
        dst_e = RNONE_ID;
        dst_m = RNONE_ID;
        case (in_code)
            I_RRMOVQ:                        dst_e = cnd ? rb : RNONE_ID;
            I_IRMOVQ, I_OPQ:                 dst_e = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = RSP;
            default:                         dst_e = RNONE_ID;
        endcase
        case (in_code)
            I_MRMOVQ, I_POPQ: dst_m = ra;
            default:          dst_m = RNONE_ID;
        endcase
    end

    // Next register contents; the M port is applied last so it wins a tie with E
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (dst_e != RNONE_ID && dst_e == 4'(i)) regs_d[i] = val_e;
            if (dst_m != RNONE_ID && dst_m == 4'(i)) regs_d[i] = val_m;
        end
    end

    // Register file state; reset clears everything and suppresses the write
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) regs_q[i] <= '0;
            else       regs_q[i] <= regs_d[i];
        end
    end

    // Read port A: current contents, no bypass of the pending write
    always_comb begin
        val_a = '0;
        for (int i = 0; i < NREGS; i++)
            if (src_a == 4'(i)) val_a = regs_q[i];
    end

    // Read port B: same as port A
    always_comb begin
        val_b = '0;
        for (int i = 0; i < NREGS; i++)
            if (src_b == 4'(i)) val_b = regs_q[i];
    end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed steps followed by random
// instruction traffic, compared against an array-based register model.
module tb_write_back;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cnd = 1'b0;
    logic [3:0]  in_code = 4'h0;
    logic [3:0]  ra = 4'h0;
    logic [3:0]  rb = 4'h0;
    logic [63:0] val_e = 64'd0;
    logic [63:0] val_m = 64'd0;
    logic [3:0]  src_a = 4'h0;
    logic [3:0]  src_b = 4'h0;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;

    int checks = 0;
    int fails  = 0;

    logic [63:0] model [16];

    write_back dut (
        .clock  (clock),
        .reset  (reset),
        .cnd    (cnd),
        .in_code(in_code),
        .ra     (ra),
        .rb     (rb),
        .val_e  (val_e),
        .val_m  (val_m),
        .src_a  (src_a),
        .src_b  (src_b),
        .val_a  (val_a),
        .val_b  (val_b),
        .dst_e  (dst_e),
        .dst_m  (dst_m)
    );

    always #50 clock = ~clock;

    function automatic logic [3:0] exp_e(input logic [3:0] ic, input logic [3:0] b, input logic c);
        case (ic)
            4'h2:                   return c ? b : 4'hF;
            4'h3, 4'h6:             return b;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] exp_m(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            src_a = 4'(i);
            src_b = 4'(15 - i);
            #1;
            chk($sformatf("%s val_a[%0d]", tag, i), val_a, model[i]);
            chk($sformatf("%s val_b[%0d]", tag, 15 - i), val_b, model[15 - i]);
        end
    endtask

    // One instruction cycle: drive, check decode and no-bypass, clock, check state
    task automatic step(input string tag, input logic rst, input logic [3:0] ic,
                        input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] e, m;
        reset = rst; in_code = ic; ra = a; rb = b; cnd = c; val_e = ve; val_m = vm;
        e = exp_e(ic, b, c);
        m = exp_m(ic, a);
        src_a = e;
        src_b = m;
        #1;
        chk({tag, " dst_e"}, {60'd0, dst_e}, {60'd0, e});
        chk({tag, " dst_m"}, {60'd0, dst_m}, {60'd0, m});
        chk({tag, " pre-edge val_a"}, val_a, model[e]);
        chk({tag, " pre-edge val_b"}, val_b, model[m]);
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = 64'd0;
        end else begin
            if (e != 4'hF) model[e] = ve;
            if (m != 4'hF) model[m] = vm;
        end
        #1;
        check_all_regs(tag);
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 64'd0;

        // Power-up reset over two edges, then read every register
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_all_regs("reset");
        chk("reset dst_e", {60'd0, dst_e}, 64'hF);
        chk("reset dst_m", {60'd0, dst_m}, 64'hF);
        @(negedge clock);

        step("irmovq",      1'b0, 4'h3, 4'd0, 4'd2, 1'b0, 64'd21,  64'd58);
        step("cmov_taken",  1'b0, 4'h2, 4'd3, 4'd2, 1'b1, 64'd81,  64'd0);
        step("cmov_not",    1'b0, 4'h2, 4'd3, 4'd2, 1'b0, 64'd77,  64'd0);
        step("rmmovq",      1'b0, 4'h4, 4'd0, 4'd4, 1'b0, 64'd81,  64'd66);
        step("popq",        1'b0, 4'hB, 4'd5, 4'd15,1'b0, 64'd261, 64'd262);
        step("popq_rsp",    1'b0, 4'hB, 4'd4, 4'd15,1'b0, 64'd100, 64'd200);
        step("irmovq_r14",  1'b0, 4'h3, 4'd15,4'd14,1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step("irmovq_rnone",1'b0, 4'h3, 4'd15,4'd15,1'b0, 64'd55,  64'd56);
        step("mrmovq",      1'b0, 4'h5, 4'd7, 4'd1, 1'b0, 64'd3,   64'd4);
        step("undef_C",     1'b0, 4'hC, 4'd7, 4'd7, 1'b1, 64'd11,  64'd12);
        step("reset_mid",   1'b1, 4'h3, 4'd0, 4'd2, 1'b0, 64'd9,   64'd0);
        step("after_reset", 1'b0, 4'h3, 4'd0, 4'd2, 1'b0, 64'd9,   64'd0);

        // Random traffic with occasional resets
        for (int n = 0; n < 200; n++) begin
            step("rand", ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
